food_spawn_ctrl: RTL and testbench
==================================

FOOD_SPAWN_CTRL -- requirements
Module: food_spawn_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- X_BITS, 8, width of the X random source and of FOOD_X.
- Y_BITS, 7, width of the Y random source and of FOOD_Y.
- MAX_X, 160, grid columns; a legal X lies in 0..MAX_X-1.
- MAX_Y, 120, grid rows; a legal Y lies in 0..MAX_Y-1.
- MAX_TRIES, 16, collision retries allowed before giving up; range 1..255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, input, 1, single clock; all state changes on rising edge.
- RESET_N, input, 1, asynchronous, active-low reset.
- SPAWN_REQ, input, 1, single-cycle request for a new food position.
- LFSR_X, input, X_BITS, free-running random X source.
- LFSR_Y, input, Y_BITS, free-running random Y source.
- LFSR_SEED, output, 1, reseed strobe to both random sources.
- CHK_REQ, output, 1, occupancy query valid.
- CHK_X, output, X_BITS, query X coordinate.
- CHK_Y, output, Y_BITS, query Y coordinate.
- CHK_ACK, input, 1, occupancy answer valid.
- CHK_HIT, input, 1, queried cell is occupied by the snake; qualified by CHK_ACK.
- FOOD_X, output, X_BITS, placed food X.
- FOOD_Y, output, Y_BITS, placed food Y.
- FOOD_VALID, output, 1, FOOD_X/FOOD_Y hold a placed position.
- BUSY, output, 1, high in every state except IDLE.
- SPAWN_FAIL, output, 1, one-cycle pulse when retries are exhausted.

Function
REQ-003 The block SHALL use a state machine with states SEED, IDLE, SAMPLE, CHECK and FAIL; all outputs SHALL be registered.
REQ-004 SEED SHALL last exactly one cycle with LFSR_SEED=1 and SHALL then go to IDLE; LFSR_SEED SHALL be 0 in every other state.
REQ-005 In IDLE, SPAWN_REQ=1 SHALL clear FOOD_VALID, clear the try counter, and move to SAMPLE on the same edge.
REQ-006 In SAMPLE, when LFSR_X<MAX_X and LFSR_Y<MAX_Y, the block SHALL capture the values into CHK_X/CHK_Y, set CHK_REQ=1 and move to CHECK.
REQ-007 In SAMPLE, an out-of-range value SHALL be discarded, the block SHALL stay in SAMPLE, and the try counter SHALL NOT change.
REQ-008 In CHECK, CHK_REQ SHALL stay 1 and CHK_X/CHK_Y SHALL stay stable until CHK_ACK=1 is sampled; CHK_ACK is legal in the first CHK_REQ cycle.
REQ-009 On CHK_ACK=1 with CHK_HIT=0, the block SHALL load FOOD_X/FOOD_Y from CHK_X/CHK_Y, set FOOD_VALID=1, drop CHK_REQ and return to IDLE.
REQ-010 On CHK_ACK=1 with CHK_HIT=1, the block SHALL increment the 8-bit try counter and drop CHK_REQ.
- If the incremented count equals MAX_TRIES, it SHALL go to FAIL.
- Otherwise it SHALL go to SAMPLE.
REQ-011 FAIL SHALL last one cycle with SPAWN_FAIL=1 and FOOD_VALID=0, then go to IDLE.
REQ-012 SPAWN_REQ SHALL be ignored outside IDLE; requests SHALL NOT be queued.
REQ-013 CHK_ACK SHALL be ignored while CHK_REQ=0.
REQ-014 Minimum latency SHALL be 3 edges, for an in-range first sample and an immediate non-hit ACK:
- edge k: SPAWN_REQ sampled.
- edge k+1: capture.
- edge k+2: ACK sampled; FOOD_VALID=1 after this edge.
REQ-015 FOOD_X, FOOD_Y and FOOD_VALID SHALL hold their values in IDLE until the next accepted SPAWN_REQ.

Reset
REQ-016 While RESET_N=0, asynchronously:
- state SHALL be SEED.
- LFSR_SEED SHALL be 1.
- CHK_REQ, FOOD_VALID and SPAWN_FAIL SHALL be 0.
- BUSY SHALL be 1.
- CHK_X, CHK_Y, FOOD_X, FOOD_Y and the try counter SHALL be 0.
REQ-017 Reset asserted in any state, including mid-handshake, SHALL abort the operation with no FOOD_VALID or SPAWN_FAIL pulse; a pending CHK_ACK SHALL be discarded.
REQ-018 After RESET_N rises, the first edge SHALL complete SEED and the second edge SHALL find the block in IDLE.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset release -> LFSR_SEED=1 for exactly 1 cycle, BUSY falls 1 cycle later, all outputs 0.
- SPAWN_REQ with LFSR_X=10, LFSR_Y=20, ACK+no hit -> CHK 10/20, FOOD_X=10, FOOD_Y=20, FOOD_VALID after 3 edges.
- LFSR_X=200 for 3 cycles, then 5 -> no CHK_REQ during the 3 cycles, try count stays 0, CHK_X=5.
- CHK_HIT=1 on every ACK, MAX_TRIES=16 -> exactly 16 CHK_REQ handshakes, one SPAWN_FAIL pulse, FOOD_VALID=0, IDLE.
- CHK_ACK delayed 5 cycles -> CHK_REQ/CHK_X/CHK_Y stable all 5 cycles; SPAWN_REQ pulsed during the wait is ignored.
- RESET_N low while CHK_REQ=1 -> CHK_REQ drops immediately, then the SEED pulse follows and no FOOD_VALID appears.

Source files
------------

// File: rtl/food_spawn_ctrl.sv
// food_spawn_ctrl: picks a random in-range grid cell, asks the snake whether it is free,
// and retries on collisions until it places food or runs out of attempts.
module food_spawn_ctrl #(
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 7,
  parameter int MAX_X     = 160,
  parameter int MAX_Y     = 120,
  parameter int MAX_TRIES = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              SPAWN_REQ,
  input  logic [X_BITS-1:0] LFSR_X,
  input  logic [Y_BITS-1:0] LFSR_Y,
  output logic              LFSR_SEED,
  output logic              CHK_REQ,
  output logic [X_BITS-1:0] CHK_X,
  output logic [Y_BITS-1:0] CHK_Y,
  input  logic              CHK_ACK,
  input  logic              CHK_HIT,
  output logic [X_BITS-1:0] FOOD_X,
  output logic [Y_BITS-1:0] FOOD_Y,
  output logic              FOOD_VALID,
  output logic              BUSY,
  output logic              SPAWN_FAIL
);
  typedef enum logic [2:0] {SEED, IDLE, SAMPLE, CHECK, FAIL} state_t;
  // Bounds widened by one bit so a limit of 2**BITS still compares correctly.
  localparam logic [X_BITS:0] MAX_XW = (X_BITS+1)'(MAX_X);
  localparam logic [Y_BITS:0] MAX_YW = (Y_BITS+1)'(MAX_Y);
  localparam logic [7:0]      MAX_TW = 8'(MAX_TRIES);
  state_t            state_q, state_d;
  logic              seed_q, seed_d;
  logic              chk_req_q, chk_req_d;
  logic [X_BITS-1:0] chk_x_q, chk_x_d;
  logic [Y_BITS-1:0] chk_y_q, chk_y_d;
  logic [X_BITS-1:0] food_x_q, food_x_d;
  logic [Y_BITS-1:0] food_y_q, food_y_d;
  logic              food_valid_q, food_valid_d;
  logic              busy_q, busy_d;
  logic              fail_q, fail_d;
  logic [7:0]        try_q, try_d;
  logic              in_range;
  logic [7:0]        try_inc;
  assign in_range = ({1'b0, LFSR_X} < MAX_XW) && ({1'b0, LFSR_Y} < MAX_YW);
  assign try_inc  = try_q + 8'd1;
  always_comb begin
    state_d      = state_q;
    chk_req_d    = chk_req_q;
    chk_x_d      = chk_x_q;
    chk_y_d      = chk_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    try_d        = try_q;
    case (state_q)
      SEED: state_d = IDLE;
      IDLE:
        if (SPAWN_REQ) begin
          food_valid_d = 1'b0;
          try_d        = 8'd0;
          state_d      = SAMPLE;
        end
      SAMPLE:
        if (in_range) begin
          chk_x_d   = LFSR_X;
          chk_y_d   = LFSR_Y;
          chk_req_d = 1'b1;
          state_d   = CHECK;
        end
      CHECK:
        if (CHK_ACK && chk_req_q) begin
          chk_req_d = 1'b0;
          if (!CHK_HIT) begin
            food_x_d     = chk_x_q;
            food_y_d     = chk_y_q;
            food_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            try_d   = try_inc;
            state_d = (try_inc == MAX_TW) ? FAIL : SAMPLE;
          end
        end
      FAIL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered images of the state being entered.
    seed_d = state_d == SEED;
    busy_d = state_d != IDLE;
    fail_d = state_d == FAIL;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= SEED;
      seed_q       <= 1'b1;
      chk_req_q    <= 1'b0;
      chk_x_q      <= '0;
      chk_y_q      <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      busy_q       <= 1'b1;
      fail_q       <= 1'b0;
      try_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      chk_req_q    <= chk_req_d;
      chk_x_q      <= chk_x_d;
      chk_y_q      <= chk_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      busy_q       <= busy_d;
      fail_q       <= fail_d;
      try_q        <= try_d;
    end
  end
  assign LFSR_SEED  = seed_q;
  assign CHK_REQ    = chk_req_q;
  assign CHK_X      = chk_x_q;
  assign CHK_Y      = chk_y_q;
  assign FOOD_X     = food_x_q;
  assign FOOD_Y     = food_y_q;
  assign FOOD_VALID = food_valid_q;
  assign BUSY       = busy_q;
  assign SPAWN_FAIL = fail_q;
endmodule

// File: tb/tb_food_spawn_ctrl.sv
// tb_food_spawn_ctrl: directed checks of food_spawn_ctrl with a scoreboard of expected placements.
module tb_food_spawn_ctrl;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       SPAWN_REQ = 1'b0;
  logic [7:0] LFSR_X = '0;
  logic [6:0] LFSR_Y = '0;
  logic       LFSR_SEED;
  logic       CHK_REQ;
  logic [7:0] CHK_X;
  logic [6:0] CHK_Y;
  logic       CHK_ACK = 1'b0;
  logic       CHK_HIT = 1'b0;
  logic [7:0] FOOD_X;
  logic [6:0] FOOD_Y;
  logic       FOOD_VALID;
  logic       BUSY;
  logic       SPAWN_FAIL;
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic       fail;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  food_spawn_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .SPAWN_REQ(SPAWN_REQ), .LFSR_X(LFSR_X), .LFSR_Y(LFSR_Y),
    .LFSR_SEED(LFSR_SEED), .CHK_REQ(CHK_REQ), .CHK_X(CHK_X), .CHK_Y(CHK_Y),
    .CHK_ACK(CHK_ACK), .CHK_HIT(CHK_HIT), .FOOD_X(FOOD_X), .FOOD_Y(FOOD_Y),
    .FOOD_VALID(FOOD_VALID), .BUSY(BUSY), .SPAWN_FAIL(SPAWN_FAIL)
  );
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic spawn(input logic [7:0] x, input logic [6:0] y, input logic fail);
    exp_t e;
    e.x = x;
    e.y = y;
    e.fail = fail;
    sb.push_back(e);
    LFSR_X = x;
    LFSR_Y = y;
    SPAWN_REQ = 1'b1;
    step();
    SPAWN_REQ = 1'b0;
  endtask
  task automatic pop_food(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(FOOD_VALID), 32'(!e.fail));
      chk({tag, "_x"}, 32'(FOOD_X), 32'(e.x));
      chk({tag, "_y"}, 32'(FOOD_Y), 32'(e.y));
    end
  endtask
  task automatic wait_food(input string tag, input int bound);
    int n = 0;
    while (!FOOD_VALID && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(FOOD_VALID), 1);
  endtask
  initial begin
    int hs, pulses, hs_at_fail, fv_seen;
    logic acked;
    exp_t e;
    // Reset state
    step();
    step();
    chk("rst_seed", 32'(LFSR_SEED), 1);
    chk("rst_busy", 32'(BUSY), 1);
    chk("rst_outs", 32'({CHK_REQ, FOOD_VALID, SPAWN_FAIL}), 0);
    chk("rst_coords", 32'({CHK_X, CHK_Y, FOOD_X, FOOD_Y}), 0);
    chk("rst_try", 32'(dut.try_q), 0);
    RESET_N = 1'b1;
    step();
    chk("seed_done", 32'(LFSR_SEED), 0);
    chk("idle_busy", 32'(BUSY), 0);
    chk("idle_outs", 32'({CHK_REQ, FOOD_VALID, SPAWN_FAIL}), 0);
    // Stray ACK in IDLE is ignored
    CHK_ACK = 1'b1;
    step();
    CHK_ACK = 1'b0;
    chk("stray_ack", 32'({FOOD_VALID, CHK_REQ, BUSY}), 0);
    // Minimum-latency placement at 10/20
    spawn(8'd10, 7'd20, 1'b0);
    chk("k_busy", 32'(BUSY), 1);
    chk("k_noreq", 32'({CHK_REQ, FOOD_VALID}), 0);
    step();
    chk("k1_req", 32'(CHK_REQ), 1);
    chk("k1_xy", 32'({CHK_X, CHK_Y}), 32'({8'd10, 7'd20}));
    chk("k1_nofood", 32'(FOOD_VALID), 0);
    CHK_ACK = 1'b1;
    step();
    CHK_ACK = 1'b0;
    pop_food("lat3");
    chk("lat3_idle", 32'({CHK_REQ, BUSY}), 0);
    step();
    chk("hold_food", 32'({FOOD_VALID, FOOD_X, FOOD_Y}), 32'({1'b1, 8'd10, 7'd20}));
    // Out-of-range samples are discarded, including both exact bounds
    spawn(8'd200, 7'd5, 1'b0);
    sb.delete(sb.size() - 1);
    sb.push_back('{x: 8'd5, y: 7'd119, fail: 1'b0});
    chk("oor_cleared", 32'(FOOD_VALID), 0);
    CHK_ACK = 1'b1;
    step();
    chk("oor0_noreq", 32'(CHK_REQ), 0);
    chk("oor0_try", 32'(dut.try_q), 0);
    LFSR_X = 8'd160;
    step();
    chk("oor1_noreq", 32'(CHK_REQ), 0);
    chk("oor1_try", 32'(dut.try_q), 0);
    LFSR_X = 8'd5;
    LFSR_Y = 7'd120;
    step();
    chk("oor2_noreq", 32'(CHK_REQ), 0);
    chk("oor2_try", 32'(dut.try_q), 0);
    CHK_ACK = 1'b0;
    LFSR_Y = 7'd119;
    step();
    chk("oor_cap_req", 32'(CHK_REQ), 1);
    chk("oor_cap_xy", 32'({CHK_X, CHK_Y}), 32'({8'd5, 7'd119}));
    CHK_ACK = 1'b1;
    step();
    CHK_ACK = 1'b0;
    wait_food("oor", 4);
    pop_food("oor");
    // Every query hits: retries run out
    spawn(8'd30, 7'd40, 1'b1);
    hs = 0;
    pulses = 0;
    hs_at_fail = 0;
    fv_seen = 0;
    for (int c = 0; c < 50; c++) begin
      acked = CHK_REQ;
      CHK_ACK = CHK_REQ;
      CHK_HIT = 1'b1;
      LFSR_X = 8'(c * 3);
      LFSR_Y = 7'(c * 2);
      step();
      if (acked) hs++;
      if (SPAWN_FAIL) begin
        pulses++;
        hs_at_fail = hs;
      end
      if (FOOD_VALID) fv_seen = 1;
    end
    CHK_ACK = 1'b0;
    CHK_HIT = 1'b0;
    chk("ex_handshakes", 32'(hs), 16);
    chk("ex_pulses", 32'(pulses), 1);
    chk("ex_fail_at", 32'(hs_at_fail), 16);
    chk("ex_nofood", 32'(fv_seen), 0);
    chk("ex_idle", 32'({BUSY, CHK_REQ, FOOD_VALID}), 0);
    chk("ex_try", 32'(dut.try_q), 16);
    chk("ex_sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ex_sb_fail", 32'(pulses != 0), 32'(e.fail));
    end
    // Delayed ACK: query held stable, request during the wait ignored
    spawn(8'd77, 7'd88, 1'b0);
    step();
    for (int c = 0; c < 5; c++) begin
      SPAWN_REQ = (c == 2);
      LFSR_X = 8'd1;
      LFSR_Y = 7'd2;
      step();
      chk("hold_req", 32'({CHK_REQ, CHK_X, CHK_Y}), 32'({1'b1, 8'd77, 7'd88}));
    end
    SPAWN_REQ = 1'b0;
    CHK_ACK = 1'b1;
    step();
    CHK_ACK = 1'b0;
    pop_food("dly");
    step();
    step();
    chk("dly_not_queued", 32'({BUSY, CHK_REQ}), 0);
    chk("dly_held", 32'({FOOD_VALID, FOOD_X}), 32'({1'b1, 8'd77}));
    // Reset in the middle of a handshake aborts it
    LFSR_X = 8'd50;
    LFSR_Y = 7'd60;
    SPAWN_REQ = 1'b1;
    step();
    SPAWN_REQ = 1'b0;
    step();
    chk("mid_req", 32'(CHK_REQ), 1);
    CHK_ACK = 1'b1;
    #1 RESET_N = 1'b0;
    #1;
    chk("mid_async_req", 32'(CHK_REQ), 0);
    chk("mid_async_seed", 32'({LFSR_SEED, BUSY}), 32'(2'b11));
    chk("mid_async_food", 32'({FOOD_VALID, FOOD_X, FOOD_Y}), 0);
    step();
    RESET_N = 1'b1;
    chk("mid_seed_hold", 32'(LFSR_SEED), 1);
    step();
    CHK_ACK = 1'b0;
    chk("mid_seed_done", 32'({LFSR_SEED, BUSY}), 0);
    fv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (FOOD_VALID || SPAWN_FAIL || CHK_REQ) fv_seen = 1;
    end
    chk("mid_no_pulse", 32'(fv_seen), 0);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
